// File: rtl/seq_player_pkg.sv
// Shared constants and types for the color-sequence playback engine:
// bus address map, color codes, status word layout and FSM states.
package seq_player_pkg;

    // Processor data-memory addresses owned by the player
    localparam logic [11:0] SEQ_PUSH_ADDR = 12'd9;
    localparam logic [11:0] SEQ_CTRL_ADDR = 12'd10;
    localparam logic [11:0] SEQ_STAT_ADDR = 12'd11;

    // Color encoding shared with the LED and audio drivers
    localparam logic [1:0] COLOR_RED    = 2'b00;
    localparam logic [1:0] COLOR_BLUE   = 2'b01;
    localparam logic [1:0] COLOR_GREEN  = 2'b10;
    localparam logic [1:0] COLOR_YELLOW = 2'b11;

    // Status word bit positions; the FIFO count starts at STAT_COUNT_LSB
    localparam int STAT_BUSY      = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_EMPTY     = 2;
    localparam int STAT_OVERFLOW  = 3;
    localparam int STAT_COUNT_LSB = 4;

    // Playback FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } seq_state_t;

    // Width of a down-counter that must hold values up to max(a, b) - 1
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/seq_player_color_fifo.sv
// Synchronous FIFO of 2-bit color codes with push, pop and flush.
// Flush wins over push and pop in the same cycle. The head entry is
// presented combinationally on rdata so the consumer can latch it on pop.
module color_fifo
    import seq_player_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [1:0]               wdata,
    output logic [1:0]               rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [1:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Accept only what the FIFO can honour; a flush cancels both sides
    always_comb begin
        push_ok = push && !full && !flush;
        pop_ok  = pop && !empty && !flush;
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset since pointers gate visibility
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    // Head of queue and occupancy flags
    always_comb begin
        rdata = mem[rd_ptr];
        full  = (count == CNT_FULL);
        empty = (count == '0);
    end

endmodule

// File: rtl/seq_player.sv
// Memory-mapped color-sequence playback engine. Stores to the push address
// queue colors; the FSM replays each for ON_CYCLES clocks followed by a
// GAP_CYCLES silent gap. A control store can flush everything, and a load
// from the status address returns busy/full/empty/overflow/count.
module seq_player
    import seq_player_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int ON_CYCLES  = 25_000_000,
    parameter int GAP_CYCLES = 12_500_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wEn,
    input  logic [11:0] addr,
    input  logic [31:0] dataIn,
    output logic [31:0] dataOut,
    output logic        tone_on,
    output logic [1:0]  color_out,
    output logic        busy
);

    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int TMR_W = timer_width(ON_CYCLES, GAP_CYCLES);
    localparam logic [TMR_W-1:0] ON_LOAD  = TMR_W'(ON_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic [TMR_W-1:0] cnt;
    logic [TMR_W-1:0] cnt_nxt;

    logic             push_req;
    logic             flush_req;
    logic             pop_req;
    logic             overflow;

    logic [1:0]       fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;

    logic             unused_data_bits;

    // Store-path decode: push and control strobes
    always_comb begin
        push_req  = wEn && (addr == SEQ_PUSH_ADDR);
        flush_req = wEn && (addr == SEQ_CTRL_ADDR) && dataIn[0];
    end

    assign unused_data_bits = ^dataIn[31:2];

    color_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_req),
        .pop   (pop_req),
        .flush (flush_req),
        .wdata (dataIn[1:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // FSM state, timer and registered playback outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            tone_on   <= 1'b0;
            color_out <= COLOR_RED;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            tone_on <= (state_nxt == ST_ON);
            if (pop_req) color_out <= fifo_rdata;
        end
    end

    // Sticky overflow: set by a dropped push, cleared only by flush or reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (flush_req) begin
            overflow <= 1'b0;
        end else if (push_req && fifo_full) begin
            overflow <= 1'b1;
        end
    end

    // Next-state and timer reload; a flush forces IDLE from any state
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (flush_req) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop_req) begin
                        state_nxt = ST_ON;
                        cnt_nxt   = ON_LOAD;
                    end
                end
                ST_ON: begin
                    if (cnt == '0) begin
                        state_nxt = ST_GAP;
                        cnt_nxt   = GAP_LOAD;
                    end else begin
                        cnt_nxt = cnt - TMR_ONE;
                    end
                end
                ST_GAP: begin
                    if (cnt == '0) begin
                        if (pop_req) begin
                            state_nxt = ST_ON;
                            cnt_nxt   = ON_LOAD;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        cnt_nxt = cnt - TMR_ONE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Pop whenever the FSM is ready for a new color and one is queued;
    // leaving GAP straight into ON avoids an idle cycle between colors
    always_comb begin
        pop_req = !flush_req && !fifo_empty &&
                  ((state == ST_IDLE) || ((state == ST_GAP) && (cnt == '0)));
        busy    = (state != ST_IDLE) || !fifo_empty;
    end

    // Status word, driven only while the status address is selected
    always_comb begin
        dataOut = '0;
        if (addr == SEQ_STAT_ADDR) begin
            dataOut[STAT_BUSY]             = busy;
            dataOut[STAT_FULL]             = fifo_full;
            dataOut[STAT_EMPTY]            = fifo_empty;
            dataOut[STAT_OVERFLOW]         = overflow;
            dataOut[STAT_COUNT_LSB +: CW]  = fifo_count;
        end
    end

endmodule
